encoder_round_scheduler: RTL and testbench
==========================================

Name: encoder_round_scheduler

Overview:
Top-level sequencer for the matrix-encoder step functions (column-parity, rotate, permutation, revaluate, add-round-constant). Each step is a self-contained start/done unit that processes the 64-line, 25-bit state file. This block fires the steps in fixed order for NUM_ROUNDS rounds and ping-pongs the source/destination state buffer between steps. It also guards every step with a watchdog and exposes round/step progress to the testbench top.

Parameters:
NUM_STEPS, 5, number of step units sequenced per round (index 0 runs first)
NUM_ROUNDS, 24, rounds per encode operation
ROUND_W, 5, width of round_idx; must satisfy 2^ROUND_W >= NUM_ROUNDS
STEP_W, 3, width of step_idx; must satisfy 2^STEP_W >= NUM_STEPS
TIMEOUT, 4096, max cycles allowed in WAIT for one step before error
TMO_W, 13, watchdog width; must satisfy 2^TMO_W > TIMEOUT

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin an encode operation; sampled only in IDLE, ERROR or FINISH-held
abort  in  1  cancel the running operation; return to IDLE
step_done  in  NUM_STEPS  level done flags from the step units
step_start  out  NUM_STEPS  one-hot, single-cycle start pulse to the selected step
buf_sel  out  1  0: step reads buffer A / writes B; 1: reads B / writes A
round_idx  out  ROUND_W  current round, 0..NUM_ROUNDS-1
step_idx  out  STEP_W  current step, 0..NUM_STEPS-1
busy  out  1  high in LAUNCH/WAIT/ADVANCE
done  out  1  sticky: operation completed; cleared on accepted start or rst
error  out  1  sticky: watchdog expired; cleared on accepted start or rst

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; step_start=0, buf_sel=0, round_idx=0, step_idx=0, busy=0, done=0, error=0, watchdog=0, done_q=0.
- Priority each cycle: rst > abort > normal FSM.
- States: IDLE, LAUNCH, WAIT, ADVANCE.
- IDLE: start=1 -> LAUNCH. On the same edge: round_idx=0, step_idx=0, buf_sel=0, done=0, error=0.
- LAUNCH (1 cycle): step_start[step_idx]=1 (registered output, high only in this cycle). watchdog<=0. done_q<=step_done[step_idx]. -> WAIT.
- WAIT: done_q<=step_done[step_idx] every cycle; rise = step_done[step_idx] & ~done_q.
  - rise=1 -> ADVANCE.
  - Otherwise watchdog++. When watchdog==TIMEOUT-1 with no rise: error=1 -> IDLE. round_idx and step_idx keep the failing position.
- A done level already high when LAUNCH is entered is not accepted. Only a fresh 0->1 transition completes a step; a level held high throughout WAIT ends in timeout.
- ADVANCE (1 cycle): buf_sel toggles.
  - If step_idx<NUM_STEPS-1: step_idx++ -> LAUNCH.
  - Else step_idx=0, and:
    - if round_idx<NUM_ROUNDS-1: round_idx++ -> LAUNCH;
    - else done=1, leave buf_sel at its toggled value (final buffer location), round_idx=NUM_ROUNDS-1, -> IDLE.
- Per-step overhead: 2 cycles plus step latency. A step whose done rises k cycles after its start pulse costs k+2 cycles.
- abort=1 in any state other than IDLE -> IDLE next edge; no step_start that cycle; done and error unchanged; indices hold. abort in IDLE has no effect.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins (no start).
- step_done bits of non-selected steps are ignored.
- Final buf_sel = (NUM_STEPS*NUM_ROUNDS) mod 2; 0 for the defaults (120 steps).

Decomposition:
- Shared package encoder_pkg:
  - state enumeration constants (IDLE=0, LAUNCH=1, WAIT=2, ADVANCE=3), 2-bit state width;
  - step index constants (STEP_PARITY=0, STEP_ROTATE=1, STEP_PERMUTE=2, STEP_REVAL=3, STEP_ADDRC=4);
  - default NUM_ROUNDS and TIMEOUT.
- One sub-module: step_watchdog. Inputs clk, rst, clr, en; output expired. Synchronous-clear counter reaching TIMEOUT-1.
- The FSM and index counters stay in the top.

Test Plan:
- NUM_STEPS=2, NUM_ROUNDS=2. Mock steps raise done 3 cycles after their start pulse and drop it on the next start. Pulse start -> step_start pulses 0,1,0,1; buf_sel after each ADVANCE is 1,0,1,0; done=1 exactly 4*(3+2)=20 cycles after LAUNCH #1; busy low in the same cycle; error=0.
- Step 1 never raises done, TIMEOUT=16 -> error=1 after 16 WAIT cycles; round_idx=0, step_idx=1; no further step_start; next start clears error and restarts at step 0.
- step_done[0] held high before start -> not accepted; timeout fires. Then drop and re-raise it inside WAIT -> ADVANCE on the rise.
- abort asserted in WAIT of round 1, step 3 -> IDLE next edge; busy=0, done=0; the mock sees no further start pulses; indices read 1/3.
- Default parameters, done latency 70 cycles -> done after 120*72=8640 cycles; round_idx=23, buf_sel=0.
- rst mid-WAIT -> all outputs 0 on the next edge; start issued while busy is ignored (check that no restart occurs).

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the matrix-encoder round scheduler: FSM encoding,
// step-unit ordering and default operation sizing.
package encoder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_ADVANCE = 2'd3
  } state_e;

  localparam int STEP_PARITY  = 0;
  localparam int STEP_ROTATE  = 1;
  localparam int STEP_PERMUTE = 2;
  localparam int STEP_REVAL   = 3;
  localparam int STEP_ADDRC   = 4;

  localparam int DEF_NUM_STEPS  = STEP_ADDRC + 1;
  localparam int DEF_NUM_ROUNDS = 24;
  localparam int DEF_TIMEOUT    = 4096;

endpackage

// File: rtl/step_watchdog.sv
// Per-step watchdog: counts cycles spent waiting on a step unit and flags
// expiry once the count reaches TIMEOUT-1.
module step_watchdog
  import encoder_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMO_W   = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] r_count;

  assign expired = (r_count == TMO_W'(TIMEOUT - 1));

  // Holds at the limit so a late enable cannot wrap the count back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en && !expired) begin
      r_count <= r_count + TMO_W'(1);
    end
  end

endmodule

// File: rtl/encoder_round_scheduler.sv
// Fires the encoder step units in fixed order for NUM_ROUNDS rounds,
// ping-ponging the state buffer between steps and guarding each step.
module encoder_round_scheduler
  import encoder_pkg::*;
#(
  parameter int NUM_STEPS  = DEF_NUM_STEPS,
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int ROUND_W    = 5,
  parameter int STEP_W     = 3,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TMO_W      = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_STEPS-1:0] step_done,
  output logic [NUM_STEPS-1:0] step_start,
  output logic                 buf_sel,
  output logic [ROUND_W-1:0]   round_idx,
  output logic [STEP_W-1:0]    step_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  state_e               r_state;
  state_e               w_next;
  logic [NUM_STEPS-1:0] r_step_start;
  logic [NUM_STEPS-1:0] w_start_vec;
  logic                 r_buf_sel;
  logic [ROUND_W-1:0]   r_round_idx;
  logic [ROUND_W-1:0]   w_nround;
  logic [STEP_W-1:0]    r_step_idx;
  logic [STEP_W-1:0]    w_nstep;
  logic                 r_done;
  logic                 r_error;
  logic                 r_done_q;
  logic                 w_sel_done;
  logic                 w_rise;
  logic                 w_last_step;
  logic                 w_last_round;
  logic                 w_accept;
  logic                 w_adv;
  logic                 w_finish;
  logic                 w_timeout;
  logic                 w_wd_clr;
  logic                 w_wd_en;
  logic                 w_wd_expired;

  step_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_wd_expired)
  );

  always_comb begin
    w_sel_done = 1'b0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (r_step_idx == STEP_W'(i)) w_sel_done = step_done[i];
    end
  end

  // Only a fresh 0->1 edge on the selected done flag completes a step.
  assign w_rise       = (r_state == ST_WAIT) && w_sel_done && !r_done_q;
  assign w_last_step  = (r_step_idx == STEP_W'(NUM_STEPS - 1));
  assign w_last_round = (r_round_idx == ROUND_W'(NUM_ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_nstep   = r_step_idx;
    w_nround  = r_round_idx;
    w_accept  = 1'b0;
    w_adv     = 1'b0;
    w_finish  = 1'b0;
    w_timeout = 1'b0;
    w_wd_clr  = 1'b0;
    w_wd_en   = 1'b0;
    if (abort && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            w_next   = ST_LAUNCH;
            w_accept = 1'b1;
            w_nstep  = STEP_W'(STEP_PARITY);
            w_nround = '0;
          end
        end
        ST_LAUNCH: begin
          w_next   = ST_WAIT;
          w_wd_clr = 1'b1;
        end
        ST_WAIT: begin
          if (w_rise) begin
            w_next = ST_ADVANCE;
          end else if (w_wd_expired) begin
            w_next    = ST_IDLE;
            w_timeout = 1'b1;
          end else begin
            w_wd_en = 1'b1;
          end
        end
        ST_ADVANCE: begin
          w_adv = 1'b1;
          if (!w_last_step) begin
            w_nstep = r_step_idx + STEP_W'(1);
            w_next  = ST_LAUNCH;
          end else begin
            w_nstep = '0;
            if (!w_last_round) begin
              w_nround = r_round_idx + ROUND_W'(1);
              w_next   = ST_LAUNCH;
            end else begin
              w_next   = ST_IDLE;
              w_finish = 1'b1;
            end
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_start_vec = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      w_start_vec[i] = (w_next == ST_LAUNCH) && (w_nstep == STEP_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_start <= '0;
      r_buf_sel    <= 1'b0;
      r_round_idx  <= '0;
      r_step_idx   <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_done_q     <= 1'b0;
    end else begin
      r_step_start <= w_start_vec;
      r_step_idx   <= w_nstep;
      r_round_idx  <= w_nround;
      if (w_accept) begin
        r_buf_sel <= 1'b0;
        r_done    <= 1'b0;
        r_error   <= 1'b0;
      end else if (w_adv) begin
        r_buf_sel <= ~r_buf_sel;
      end
      if (w_finish) r_done <= 1'b1;
      if (w_timeout) r_error <= 1'b1;
      if ((r_state == ST_LAUNCH) || (r_state == ST_WAIT)) begin
        r_done_q <= w_sel_done;
      end
    end
  end

  assign step_start = r_step_start;
  assign buf_sel    = r_buf_sel;
  assign round_idx  = r_round_idx;
  assign step_idx   = r_step_idx;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_encoder_round_scheduler.sv
// Directed bench: a 2-step/2-round/TIMEOUT=16 instance and a default instance,
// each driven by mock step units whose done rises a fixed delay after start.
module tb_encoder_round_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Small instance signals
  logic       s_start = 1'b0, s_abort = 1'b0;
  logic [1:0] s_step_done, s_step_start;
  logic       s_buf_sel, s_busy, s_done, s_error;
  logic [4:0] s_round;
  logic [2:0] s_step;
  logic [1:0] s_mock;
  logic [1:0] s_stuck = 2'b00;
  logic       s_man_en = 1'b0;
  logic [1:0] s_man = 2'b00;
  int         s_lat = 3;
  int         s_cnt [2];
  int         s_np = 0;

  // Default instance signals
  logic       d_start = 1'b0, d_abort = 1'b0;
  logic [4:0] d_step_done, d_step_start;
  logic       d_buf_sel, d_busy, d_done, d_error;
  logic [4:0] d_round;
  logic [2:0] d_step;
  logic [4:0] d_mock;
  int         d_lat = 3;
  int         d_cnt [5];
  int         d_np = 0;

  assign s_step_done = s_man_en ? s_man : s_mock;
  assign d_step_done = d_mock;

  encoder_round_scheduler #(
    .NUM_STEPS(2), .NUM_ROUNDS(2), .ROUND_W(5), .STEP_W(3), .TIMEOUT(16), .TMO_W(13)
  ) u_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .step_done(s_step_done), .step_start(s_step_start), .buf_sel(s_buf_sel),
    .round_idx(s_round), .step_idx(s_step), .busy(s_busy), .done(s_done), .error(s_error)
  );

  encoder_round_scheduler u_dut (
    .clk(clk), .rst(rst), .start(d_start), .abort(d_abort),
    .step_done(d_step_done), .step_start(d_step_start), .buf_sel(d_buf_sel),
    .round_idx(d_round), .step_idx(d_step), .busy(d_busy), .done(d_done), .error(d_error)
  );

  // Mock step units: done drops on start and rises lat cycles after the pulse.
  always @(posedge clk) begin
    if (rst) begin
      s_mock <= 2'b00;
      for (int i = 0; i < 2; i++) s_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_step_start[i]) begin
          s_cnt[i]  <= 1;
          s_mock[i] <= 1'b0;
        end else if (s_cnt[i] != 0) begin
          if (s_cnt[i] == s_lat - 1) begin
            s_cnt[i]  <= 0;
            s_mock[i] <= ~s_stuck[i];
          end else begin
            s_cnt[i] <= s_cnt[i] + 1;
          end
        end
      end
      if (s_step_start != 2'b00) s_np <= s_np + 1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      d_mock <= 5'b0;
      for (int i = 0; i < 5; i++) d_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (d_step_start[i]) begin
          d_cnt[i]  <= 1;
          d_mock[i] <= 1'b0;
        end else if (d_cnt[i] != 0) begin
          if (d_cnt[i] == d_lat - 1) begin
            d_cnt[i]  <= 0;
            d_mock[i] <= 1'b1;
          end else begin
            d_cnt[i] <= d_cnt[i] + 1;
          end
        end
      end
      if (d_step_start != 5'b0) d_np <= d_np + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int np0;
  logic [1:0] exp_ss;

  initial begin
    tick();
    tick();
    // Reset state
    check("rst_d_step_start", 32'(d_step_start), 0);
    check("rst_d_busy", 32'(d_busy), 0);
    check("rst_d_done", 32'(d_done), 0);
    check("rst_d_error", 32'(d_error), 0);
    check("rst_d_idx", {d_round, d_step, d_buf_sel}, 0);
    check("rst_s_busy", 32'(s_busy), 0);
    rst = 1'b0;
    tick();

    // start and abort together in IDLE: abort wins
    d_start = 1'b1;
    d_abort = 1'b1;
    tick();
    d_start = 1'b0;
    d_abort = 1'b0;
    check("idle_abort_wins_busy", 32'(d_busy), 0);
    tick();
    check("idle_abort_wins_start", 32'(d_step_start), 0);

    // Small instance: full 2x2 sequence, 5 cycles per step
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      exp_ss = 2'b00;
      if ((c % 5 == 0) && (c < 20)) exp_ss = ((c / 5) % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("seq_step_start_c%0d", c), 32'(s_step_start), 32'(exp_ss));
      check($sformatf("seq_buf_sel_c%0d", c), 32'(s_buf_sel), 32'((c / 5) % 2));
      check($sformatf("seq_done_c%0d", c), 32'(s_done), (c == 20) ? 1 : 0);
      check($sformatf("seq_busy_c%0d", c), 32'(s_busy), (c < 20) ? 1 : 0);
    end
    check("seq_error", 32'(s_error), 0);
    check("seq_final_round", 32'(s_round), 1);

    // Step 1 never completes: timeout after 16 WAIT cycles
    s_stuck = 2'b10;
    np0 = s_np;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("tmo_done_cleared", 32'(s_done), 0);
    for (int c = 1; c <= 21; c++) tick();
    check("tmo_busy_before", 32'(s_busy), 1);
    check("tmo_error_before", 32'(s_error), 0);
    tick();
    check("tmo_error", 32'(s_error), 1);
    check("tmo_busy", 32'(s_busy), 0);
    check("tmo_round", 32'(s_round), 0);
    check("tmo_step", 32'(s_step), 1);
    for (int c = 0; c < 10; c++) tick();
    check("tmo_no_more_starts", 32'(s_np - np0), 2);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("tmo_restart_error", 32'(s_error), 0);
    check("tmo_restart_start", 32'(s_step_start), 1);
    check("tmo_restart_step", 32'(s_step), 0);
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
    check("tmo_abort_busy", 32'(s_busy), 0);

    // Done level already high at LAUNCH is not accepted
    s_man_en = 1'b1;
    s_man = 2'b01;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int c = 1; c <= 16; c++) tick();
    check("held_busy_before", 32'(s_busy), 1);
    check("held_error_before", 32'(s_error), 0);
    tick();
    check("held_error", 32'(s_error), 1);
    check("held_step", 32'(s_step), 0);
    check("held_busy", 32'(s_busy), 0);
    // Drop and re-raise inside WAIT completes the step
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick();
    s_man = 2'b00;
    tick();
    tick();
    s_man = 2'b01;
    tick();
    check("rerise_advance_nostart", 32'(s_step_start), 0);
    check("rerise_advance_busy", 32'(s_busy), 1);
    tick();
    check("rerise_next_start", 32'(s_step_start), 2);
    check("rerise_step", 32'(s_step), 1);
    check("rerise_buf_sel", 32'(s_buf_sel), 1);
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
    s_man_en = 1'b0;

    // Default instance: abort in WAIT of round 1, step 3
    d_lat = 3;
    np0 = d_np;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    for (int c = 1; c <= 41; c++) tick();
    check("abort_pre_round", 32'(d_round), 1);
    check("abort_pre_step", 32'(d_step), 3);
    d_abort = 1'b1;
    tick();
    d_abort = 1'b0;
    check("abort_busy", 32'(d_busy), 0);
    check("abort_done", 32'(d_done), 0);
    check("abort_error", 32'(d_error), 0);
    check("abort_round", 32'(d_round), 1);
    check("abort_step", 32'(d_step), 3);
    for (int c = 0; c < 10; c++) tick();
    check("abort_pulses", 32'(d_np - np0), 9);
    check("abort_idle_start", 32'(d_step_start), 0);

    // Default instance: full run with 70-cycle steps, start while busy ignored
    d_lat = 70;
    np0 = d_np;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    check("full_launch_start", 32'(d_step_start), 1);
    for (int c = 1; c <= 8640; c++) begin
      tick();
      if (c == 100) d_start = 1'b1;
      if (c == 101) begin
        d_start = 1'b0;
        check("busy_start_step", 32'(d_step), 1);
        check("busy_start_round", 32'(d_round), 0);
      end
      if (c == 8639) begin
        check("full_done_early", 32'(d_done), 0);
        check("full_busy_early", 32'(d_busy), 1);
      end
    end
    check("full_done", 32'(d_done), 1);
    check("full_busy", 32'(d_busy), 0);
    check("full_round", 32'(d_round), 23);
    check("full_step", 32'(d_step), 0);
    check("full_buf_sel", 32'(d_buf_sel), 0);
    check("full_error", 32'(d_error), 0);
    check("full_pulses", 32'(d_np - np0), 120);

    // Reset in the middle of WAIT
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    check("rst_run_done_cleared", 32'(d_done), 0);
    for (int c = 1; c <= 100; c++) tick();
    check("rst_pre_step", 32'(d_step), 1);
    check("rst_pre_buf_sel", 32'(d_buf_sel), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_step_start", 32'(d_step_start), 0);
    check("midrst_buf_sel", 32'(d_buf_sel), 0);
    check("midrst_round", 32'(d_round), 0);
    check("midrst_step", 32'(d_step), 0);
    check("midrst_busy", 32'(d_busy), 0);
    check("midrst_done", 32'(d_done), 0);
    check("midrst_error", 32'(d_error), 0);
    check("midrst_s_error", 32'(s_error), 0);
    for (int c = 0; c < 5; c++) tick();
    check("midrst_stay_idle", 32'(d_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
